mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (datapath word width).
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nReset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port Start  input  1  multiply request from control during Execute of MULT.
REQ-005 SHALL have port Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-006 SHALL have port OpA  input  WIDTH  multiplicand (register-file operand); sampled with Start.
REQ-007 SHALL have port OpB  input  WIDTH  multiplier (accumulator operand); sampled with Start.
REQ-008 SHALL have port Abort  input  1  cancel an operation in progress.
REQ-009 SHALL have port Busy  output  1  high while an operation is in progress; control holds PcSel at PcWait while high.
REQ-010 SHALL have port Done  output  1  single-cycle pulse, Product valid.
REQ-011 SHALL have port Product  output  2*WIDTH  full-width result, held until the next completed operation.
REQ-012 SHALL have port Ovf  output  1  result does not fit in WIDTH bits (signed or unsigned per captured mode).

Function
REQ-013 SHALL implement state machine states IDLE, RUN, FIX, DONE; all outputs registered.
REQ-014 IDLE: Start=1 SHALL capture operands, mode, |OpA|, |OpB| (signed mode) and result sign = sign(OpA) XOR sign(OpB); next state RUN; bit counter = 0; partial product = 0.
REQ-015 Start in IDLE while Abort=1 SHALL be ignored; state remains IDLE.
REQ-016 RUN: SHALL perform one radix-2 shift-add step per cycle (add shifted multiplicand when current multiplier bit = 1); counter increments; after exactly WIDTH RUN cycles, next state FIX.
REQ-017 Magnitude of the most negative value (e.g. -128 for WIDTH=8) SHALL be handled as unsigned 2^(WIDTH-1) without loss.
REQ-018 FIX: SHALL negate the 2*WIDTH magnitude (two's complement) when signed mode and result sign = 1 and magnitude != 0; a zero result SHALL never be negated; next state DONE.
REQ-019 DONE: Product and Ovf SHALL update at entry to DONE; Done=1 for exactly this one cycle; next state IDLE.
REQ-020 Latency: Start accepted in cycle N SHALL give Done=1 in cycle N+WIDTH+2 (N+10 for WIDTH=8).
REQ-021 Busy SHALL be 1 in RUN, FIX and DONE, and 0 in IDLE.
REQ-022 Start while Busy=1 SHALL be ignored (no queueing, no effect on operation in progress).
REQ-023 Start in the IDLE cycle directly following DONE SHALL be accepted (back-to-back throughput WIDTH+3 cycles).
REQ-024 Abort=1 in RUN or FIX SHALL force IDLE at the next edge; no Done pulse; Product and Ovf keep their prior values.
REQ-025 Abort=1 in DONE SHALL have no effect (result already committed).
REQ-026 Ovf unsigned SHALL be 1 iff Product[2*WIDTH-1:WIDTH] != 0.
REQ-027 Ovf signed SHALL be 1 iff Product[2*WIDTH-1:WIDTH-1] is not all-zeros or all-ones.

Reset
REQ-028 nReset=0 at a rising edge SHALL set state IDLE, Busy=0, Done=0, Product=0, Ovf=0, counter=0, regardless of Start/Abort.
REQ-029 Reset mid-operation SHALL discard the operation; no Done pulse after reset release.
REQ-030 The first Start SHALL be accepted in the first cycle with nReset=1.

Verification
REQ-031 Reset: nReset=0 for 2 cycles with Start=1, OpA=0x05 -> Busy=0, Done=0, Product=0x0000, Ovf=0 throughout, and no operation starts.
REQ-032 Unsigned: Start in cycle N, Signed=0, 0xFF*0xFF -> Busy=1 from N+1, Done=1 only in N+10, Product=0xFE01, Ovf=1, Busy=0 in N+11.
REQ-033 Signed: -3*5 (0xFD, 0x05) -> Product=0xFFF1, Ovf=0; -128*-128 (0x80, 0x80) -> 0x4000, Ovf=1; -7*0 -> 0x0000, Ovf=0.
REQ-034 Busy/abort: prior result 0x0019; Start with 0x02*0x03 in N, Start again with 0x09*0x09 in N+3, Abort in N+5 -> IDLE in N+6, no Done, Product stays 0x0019.
REQ-035 Reset mid-run: nReset=0 in N+4 of a 0x10*0x10 operation -> Product=0, Busy=0 next edge; no Done afterwards.
REQ-036 Back-to-back: Done in cycle M, Start with 0x7F*0x02 (Signed=1) in M+1 -> accepted; Done in M+11; Product=0x00FE, Ovf=1.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier: signed/unsigned operands, WIDTH+3 cycles
// per operation, with abort and a registered overflow flag.
module mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  input  logic               Abort,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product,
  output logic               Ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic               sgn_mode;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] result;
  logic               ovf_next;

  // Magnitudes stay unsigned, so the most negative operand maps to 2^(WIDTH-1) intact.
  always_comb begin
    mag_a = (Signed && OpA[WIDTH-1]) ? -OpA : OpA;
    mag_b = (Signed && OpB[WIDTH-1]) ? -OpB : OpB;
  end

  always_comb begin
    result   = acc;
    ovf_next = 1'b0;
    if (sgn_mode && neg && (acc != '0))
      result = -acc;
    if (sgn_mode)
      ovf_next = !((&result[2*WIDTH-1:WIDTH-1]) || (~|result[2*WIDTH-1:WIDTH-1]));
    else
      ovf_next = |result[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      sgn_mode <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Product  <= '0;
      Ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start && !Abort) begin
            state    <= RUN;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            sgn_mode <= Signed;
            neg      <= Signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
            Busy     <= 1'b1;
          end
        end
        RUN: begin
          if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            if (mplier[0])
              acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
              state <= FIX;
          end
        end
        FIX: begin
          if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            // Sign fix-up and result commit share this edge so Product is valid with Done.
            Product <= result;
            Ovf     <= ovf_next;
            Done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_mult_seq;

  logic        Clock;
  logic        nReset;
  logic        Start;
  logic        Signed;
  logic [7:0]  OpA;
  logic [7:0]  OpB;
  logic        Abort;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;
  logic        Ovf;

  int compared;
  int mismatched;
  logic [15:0] exp_prod;
  logic        exp_ovf;

  mult_seq #(.WIDTH(8)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Signed(Signed),
    .OpA(OpA), .OpB(OpB), .Abort(Abort), .Busy(Busy), .Done(Done),
    .Product(Product), .Ovf(Ovf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic eb, input logic ed);
    chk({tag, "_busy"}, 32'(Busy), 32'(eb));
    chk({tag, "_done"}, 32'(Done), 32'(ed));
    chk({tag, "_prod"}, 32'(Product), 32'(exp_prod));
    chk({tag, "_ovf"},  32'(Ovf), 32'(exp_ovf));
  endtask

  // Called at a negedge with the DUT idle; Start is driven in this cycle (N).
  // abort_k in 4..9 aborts in RUN/FIX, 10 aborts in DONE (no effect), 0 never.
  // A second Start with random operands is issued in N+3 and must be ignored.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sg,
                        input int abort_k);
    int ia, ib, prod;
    logic [15:0] p;
    logic o, aborted, eb, ed;
    ia   = sg ? int'($signed(a)) : int'(a);
    ib   = sg ? int'($signed(b)) : int'(b);
    prod = ia * ib;
    p    = prod[15:0];
    o    = sg ? (prod < -128 || prod > 127) : (prod > 255);
    chk_outputs("start", 1'b0, 1'b0);
    Start = 1'b1; Signed = sg; OpA = a; OpB = b; Abort = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge Clock);
      Start = 1'b0; Abort = 1'b0;
      if (j == 3) begin
        Start = 1'b1; OpA = 8'($urandom); OpB = 8'($urandom); Signed = 1'($urandom);
      end
      aborted = (abort_k > 0) && (abort_k < 10) && (j > abort_k);
      eb = (j <= 10) && !aborted;
      ed = (j == 10) && !aborted;
      if (ed) begin
        exp_prod = p;
        exp_ovf  = o;
      end
      chk_outputs($sformatf("op%0h_%0h_s%0d_c%0d", a, b, sg, j), eb, ed);
      if (j == abort_k) Abort = 1'b1;
    end
    Start = 1'b0; Abort = 1'b0;
  endtask

  initial begin
    compared = 0; mismatched = 0;
    exp_prod = '0; exp_ovf = 1'b0;
    nReset = 1'b0; Start = 1'b1; Signed = 1'b0; OpA = 8'h05; OpB = 8'h03; Abort = 1'b0;

    // Reset held with Start asserted: nothing may start.
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      chk_outputs($sformatf("reset%0d", i), 1'b0, 1'b0);
    end
    nReset = 1'b1;

    // First cycle out of reset accepts Start.
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    run_op(8'hFD, 8'h05, 1'b1, 0);
    run_op(8'h80, 8'h80, 1'b1, 0);
    run_op(8'hF9, 8'h00, 1'b1, 0);
    run_op(8'h05, 8'h05, 1'b0, 0);
    run_op(8'h02, 8'h03, 1'b0, 5);
    run_op(8'h7F, 8'h02, 1'b1, 0);
    run_op(8'h7F, 8'h02, 1'b1, 0);
    run_op(8'h80, 8'h7F, 1'b1, 10);
    run_op(8'h80, 8'hFF, 1'b0, 9);

    // Reset in N+4 of an operation.
    chk_outputs("rst_mid_idle", 1'b0, 1'b0);
    Start = 1'b1; Signed = 1'b0; OpA = 8'h10; OpB = 8'h10;
    for (int j = 1; j <= 4; j++) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    nReset = 1'b0;
    @(negedge Clock);
    exp_prod = '0; exp_ovf = 1'b0;
    chk_outputs("rst_mid_after", 1'b0, 1'b0);
    nReset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge Clock);
      chk_outputs($sformatf("rst_mid_quiet%0d", j), 1'b0, 1'b0);
    end

    // Randomized operations, some aborted.
    for (int i = 0; i < 30; i++) begin
      int mode;
      int ak;
      mode = int'($urandom_range(0, 3));
      ak = (mode == 1) ? int'($urandom_range(4, 9)) : (mode == 2) ? 10 : 0;
      run_op(8'($urandom), 8'($urandom), 1'($urandom), ak);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
